// File: rtl/alu_cmd_sequencer.sv
// Request/response sequencer for the 8-bit combinational ALU.
// Drives operands and command, waits a settle time, captures the result, and optionally sweeps all commands.
module alu_cmd_sequencer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CMD_W  = 4,
   parameter int          SETTLE = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [DATA_W-1:0]   req_a,
   input  logic [DATA_W-1:0]   req_b,
   input  logic [CMD_W-1:0]    req_cmd,
   input  logic                req_sweep,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [CMD_W-1:0]    alu_cmd,
   output logic                alu_oe,
   input  logic [2*DATA_W-1:0] alu_d,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [CMD_W-1:0]    rsp_cmd,
   output logic [2*DATA_W-1:0] rsp_data,
   output logic                rsp_last,
   output logic                busy
);

   localparam int unsigned RES_W      = 2 * DATA_W;
   localparam int unsigned SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
   localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);
   localparam logic [CMD_W-1:0] CMD_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_RESP
   } state_e;

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  a_q, a_d;
   logic [DATA_W-1:0]  b_q, b_d;
   logic [CMD_W-1:0]   cmd_q, cmd_d;
   logic               oe_q, oe_d;
   logic               sweep_q, sweep_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [CMD_W-1:0]   rsp_cmd_q, rsp_cmd_d;
   logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
   logic               rsp_last_q, rsp_last_d;
   logic               busy_q, busy_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         cmd_q       <= '0;
         oe_q        <= 1'b0;
         sweep_q     <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_cmd_q   <= '0;
         rsp_data_q  <= '0;
         rsp_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cmd_q       <= cmd_d;
         oe_q        <= oe_d;
         sweep_q     <= sweep_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_cmd_q   <= rsp_cmd_d;
         rsp_data_q  <= rsp_data_d;
         rsp_last_q  <= rsp_last_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      cmd_d       = cmd_q;
      oe_d        = oe_q;
      sweep_d     = sweep_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_cmd_d   = rsp_cmd_q;
      rsp_data_d  = rsp_data_q;
      rsp_last_d  = rsp_last_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               cmd_d   = req_sweep ? '0 : req_cmd;
               sweep_d = req_sweep;
               oe_d    = 1'b1;
               cnt_d   = '0;
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (cnt_q == CNT_LAST) begin
               rsp_data_d  = alu_d;
               rsp_cmd_d   = cmd_q;
               rsp_last_d  = !sweep_q || (cmd_q == CMD_MAX);
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            // rsp_valid is always high here, so rsp_ready alone completes the transfer
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (rsp_last_q) begin
                  oe_d    = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  cmd_d   = cmd_q + CMD_W'(1);
                  cnt_d   = '0;
                  state_d = S_DRIVE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign req_ready = (state_q == S_IDLE);
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_cmd   = cmd_q;
   assign alu_oe    = oe_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_cmd   = rsp_cmd_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_last  = rsp_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: one instance on a behavioural ALU (SETTLE=1),
// one on a pass-through stub ALU (SETTLE=3).
module tb_alu_cmd_sequencer;

   logic clk;
   logic rst_n;

   logic        req_valid, req_ready, req_sweep, rsp_valid, rsp_ready, rsp_last, alu_oe, busy;
   logic [7:0]  req_a, req_b, alu_a, alu_b;
   logic [3:0]  req_cmd, alu_cmd, rsp_cmd;
   logic [15:0] alu_d, rsp_data;

   logic        req_valid3, req_ready3, req_sweep3, rsp_valid3, rsp_ready3, rsp_last3, alu_oe3, busy3;
   logic [7:0]  req_a3, req_b3, alu_a3, alu_b3;
   logic [3:0]  req_cmd3, alu_cmd3, rsp_cmd3;
   logic [15:0] alu_d3, rsp_data3;

   int n_cmp = 0;
   int n_mis = 0;

   function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] c);
      case (c)
         4'd0:    alu_ref = 16'(a) + 16'(b);
         4'd1:    alu_ref = 16'(a) - 16'(b);
         4'd2:    alu_ref = 16'(a) * 16'(b);
         4'd3:    alu_ref = {8'h00, a & b};
         4'd4:    alu_ref = {8'h00, a | b};
         4'd5:    alu_ref = {8'h00, a ^ b};
         4'd6:    alu_ref = {8'h00, ~a};
         4'd7:    alu_ref = {7'h00, a, 1'b0};
         4'd8:    alu_ref = {9'h000, a[7:1]};
         4'd9:    alu_ref = {8'h00, b};
         4'd10:   alu_ref = {8'h00, a};
         4'd11:   alu_ref = {a, b};
         4'd12:   alu_ref = {b, a};
         4'd13:   alu_ref = 16'(a) + 16'd1;
         4'd14:   alu_ref = 16'(a) - 16'd1;
         default: alu_ref = {8'h00, ~(a & b)};
      endcase
   endfunction

   assign alu_d  = alu_oe ? alu_ref(alu_a, alu_b, alu_cmd) : 16'h0000;
   assign alu_d3 = {alu_cmd3, 4'h0, alu_a3};

   alu_cmd_sequencer #(.DATA_W(8), .CMD_W(4), .SETTLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .req_cmd(req_cmd), .req_sweep(req_sweep),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_oe(alu_oe), .alu_d(alu_d),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cmd(rsp_cmd), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .busy(busy)
   );

   alu_cmd_sequencer #(.DATA_W(8), .CMD_W(4), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid3), .req_ready(req_ready3), .req_a(req_a3), .req_b(req_b3),
      .req_cmd(req_cmd3), .req_sweep(req_sweep3),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_cmd(alu_cmd3), .alu_oe(alu_oe3), .alu_d(alu_d3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_cmd(rsp_cmd3), .rsp_data(rsp_data3),
      .rsp_last(rsp_last3), .busy(busy3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                        input logic sw);
      req_a     = a;
      req_b     = b;
      req_cmd   = c;
      req_sweep = sw;
      req_valid = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b1;
      req_valid  = 1'b0; req_a  = '0; req_b  = '0; req_cmd  = '0; req_sweep  = 1'b0; rsp_ready  = 1'b0;
      req_valid3 = 1'b0; req_a3 = '0; req_b3 = '0; req_cmd3 = '0; req_sweep3 = 1'b0; rsp_ready3 = 1'b0;

      // asynchronous reset asserted mid-cycle, before any clock edge
      #3 rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu_oe",    32'(alu_oe),    32'd0);
      chk("rst_alu_a",     32'(alu_a),     32'd0);
      chk("rst_alu_cmd",   32'(alu_cmd),   32'd0);
      chk("rst_rsp_data",  32'(rsp_data),  32'd0);
      chk("rst_rsp_last",  32'(rsp_last),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      #8 rst_n = 1'b1;
      tick();
      chk("post_rst_busy",  32'(busy),      32'd0);
      chk("post_rst_ready", 32'(req_ready), 32'd1);

      // single ADD, consumer ready
      rsp_ready = 1'b1;
      issue(8'hCE, 8'h9B, 4'd0, 1'b0);
      tick();
      req_valid = 1'b0;
      chk("single_drive_oe",    32'(alu_oe),    32'd1);
      chk("single_drive_ready", 32'(req_ready), 32'd0);
      chk("single_drive_a",     32'(alu_a),     32'hCE);
      chk("single_drive_valid", 32'(rsp_valid), 32'd0);
      tick();
      chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("single_rsp_data",  32'(rsp_data),  32'h0169);
      chk("single_rsp_cmd",   32'(rsp_cmd),   32'd0);
      chk("single_rsp_last",  32'(rsp_last),  32'd1);
      chk("single_rsp_oe",    32'(alu_oe),    32'd1);
      chk("single_rsp_ready", 32'(req_ready), 32'd0);
      tick();
      chk("single_done_valid", 32'(rsp_valid), 32'd0);
      chk("single_done_oe",    32'(alu_oe),    32'd0);
      chk("single_done_ready", 32'(req_ready), 32'd1);
      chk("single_done_busy",  32'(busy),      32'd0);
      chk("single_hold_a",     32'(alu_a),     32'hCE);

      // back-pressure with a stray request pulse while busy
      rsp_ready = 1'b0;
      issue(8'h12, 8'h34, 4'd3, 1'b0);
      tick();
      req_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_data",  32'(rsp_data),  32'h0010);
         chk("bp_cmd",   32'(rsp_cmd),   32'd3);
         chk("bp_alu_a", 32'(alu_a),     32'h12);
         if (i == 1) issue(8'hFF, 8'hFF, 4'd2, 1'b0);
         if (i == 2) req_valid = 1'b0;
         tick();
      end
      chk("bp_still_valid", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      tick();
      chk("bp_xfer_valid", 32'(rsp_valid), 32'd0);
      chk("bp_xfer_ready", 32'(req_ready), 32'd1);
      chk("bp_xfer_a",     32'(alu_a),     32'h12);
      tick();
      chk("bp_idle_busy", 32'(busy), 32'd0);

      // full sweep, consumer always ready; req_cmd must be ignored
      issue(8'hCE, 8'h9B, 4'd7, 1'b1);
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         chk("sweep_valid", 32'(rsp_valid), 32'd1);
         chk("sweep_cmd",   32'(rsp_cmd),   32'(k));
         chk("sweep_data",  32'(rsp_data),  32'(alu_ref(8'hCE, 8'h9B, 4'(k))));
         chk("sweep_last",  32'(rsp_last),  32'(k == 15));
         if (k == 2) chk("sweep_mul_data", 32'(rsp_data), 32'h7CBA);
         tick();
         chk("sweep_gap_valid", 32'(rsp_valid), 32'd0);
         chk("sweep_gap_busy",  32'(busy),      32'(k != 15));
      end
      chk("sweep_end_oe",    32'(alu_oe),    32'd0);
      chk("sweep_end_ready", 32'(req_ready), 32'd1);

      // SETTLE=3 against stub ALU
      req_a3 = 8'h12; req_b3 = 8'h77; req_cmd3 = 4'd5; req_sweep3 = 1'b0; req_valid3 = 1'b1;
      tick();
      req_valid3 = 1'b0;
      for (int j = 0; j < 3; j++) begin
         chk("s3_wait_valid", 32'(rsp_valid3), 32'd0);
         chk("s3_wait_oe",    32'(alu_oe3),    32'd1);
         tick();
      end
      chk("s3_valid", 32'(rsp_valid3), 32'd1);
      chk("s3_data",  32'(rsp_data3),  32'h5012);
      chk("s3_cmd",   32'(rsp_cmd3),   32'd5);
      chk("s3_last",  32'(rsp_last3),  32'd1);
      chk("s3_alu_b", 32'(alu_b3),     32'h77);
      chk("s3_busy",  32'(busy3),      32'd1);
      rsp_ready3 = 1'b1;
      tick();
      chk("s3_done_valid", 32'(rsp_valid3), 32'd0);
      chk("s3_done_ready", 32'(req_ready3), 32'd1);

      // reset in the middle of a sweep
      issue(8'hCE, 8'h9B, 4'd0, 1'b1);
      tick();
      req_valid = 1'b0;
      repeat (7) begin
         tick();
         tick();
      end
      tick();
      chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
      chk("mid_pre_cmd",   32'(rsp_cmd),   32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_oe",    32'(alu_oe),    32'd0);
      chk("mid_rst_busy",  32'(busy),      32'd0);
      chk("mid_rst_cmd",   32'(alu_cmd),   32'd0);
      chk("mid_rst_data",  32'(rsp_data),  32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      chk("mid_after_valid", 32'(rsp_valid), 32'd0);
      issue(8'h05, 8'h03, 4'd1, 1'b0);
      tick();
      req_valid = 1'b0;
      chk("mid_new_valid0", 32'(rsp_valid), 32'd0);
      tick();
      chk("mid_new_valid", 32'(rsp_valid), 32'd1);
      chk("mid_new_data",  32'(rsp_data),  32'h0002);
      chk("mid_new_cmd",   32'(rsp_cmd),   32'd1);
      chk("mid_new_last",  32'(rsp_last),  32'd1);
      tick();
      chk("mid_new_done", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
